// File: rtl/ex_arb_pkg.sv
// ex_arb_pkg: shared FSM states, owner encoding and ALU opcodes for ex_alu_arbiter
package ex_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic OWN_EX   = 1'b0;
  localparam logic OWN_HOST = 1'b1;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
endpackage

// File: rtl/ex_alu_arbiter_alu.sv
// alu: combinational ALU shared by the EX pipeline and the host/debug port
//   A, B     operands
//   aluctrl  operation code (ALU_* from ex_arb_pkg)
//   Z        result
//   overflow unsigned carry for ADD, borrow (A<B) for SUB/SLTU, else 0;
//            after SUB, zero/overflow/neither read as equal/less/greater
module alu
  import ex_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    A,
  input  logic [DATA_WIDTH-1:0]    B,
  input  logic [ALUCTRL_WIDTH-1:0] aluctrl,
  output logic [DATA_WIDTH-1:0]    Z,
  output logic                     overflow
);
  logic [DATA_WIDTH:0] sum, dif;
  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = {1'b0, A} - {1'b0, B};
  always_comb begin
    Z = aluctrl == ALUCTRL_WIDTH'(ALU_ADD)  ? sum[DATA_WIDTH-1:0] :
        aluctrl == ALUCTRL_WIDTH'(ALU_SUB)  ? dif[DATA_WIDTH-1:0] :
        aluctrl == ALUCTRL_WIDTH'(ALU_AND)  ? A & B :
        aluctrl == ALUCTRL_WIDTH'(ALU_OR)   ? A | B :
        aluctrl == ALUCTRL_WIDTH'(ALU_XOR)  ? A ^ B :
        aluctrl == ALUCTRL_WIDTH'(ALU_SLTU) ? {{(DATA_WIDTH-1){1'b0}}, dif[DATA_WIDTH]} : '0;
    overflow = aluctrl == ALUCTRL_WIDTH'(ALU_ADD) ? sum[DATA_WIDTH] :
               (aluctrl == ALUCTRL_WIDTH'(ALU_SUB) || aluctrl == ALUCTRL_WIDTH'(ALU_SLTU)) ? dif[DATA_WIDTH] : 1'b0;
  end
endmodule

// File: rtl/ex_alu_arbiter.sv
// ex_alu_arbiter: shares one ALU between pipeline EX (req0) and host/debug (req1), one op in flight
//   clk, rst_n               clock, async active-low reset
//   reqN_valid/ready         request handshake; reqN_a, reqN_b, reqN_ctrl operands and opcode
//   rspN_valid/ready         response handshake for the owner of the in-flight op
//   rsp_data/zero/ovf        shared registered result and flags, qualified by rspN_valid
//   busy                     FSM not in IDLE
//   EX_ARB_RR_EN defined     round-robin on ties; otherwise req0 wins ties
module ex_alu_arbiter
  import ex_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [ALUCTRL_WIDTH-1:0] req0_ctrl,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [ALUCTRL_WIDTH-1:0] req1_ctrl,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_zero,
  output logic                     rsp_ovf,
  output logic                     busy
);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] a_q, b_q, z;
  logic [ALUCTRL_WIDTH-1:0] ctrl_q;
  logic owner_q, ovf, win, accept;
`ifdef EX_ARB_RR_EN
  logic last_grant;
  assign win = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= OWN_HOST;
    else if (accept) last_grant <= win;
`else
  assign win = ~req0_valid;
`endif
  alu #(.DATA_WIDTH(DATA_WIDTH), .ALUCTRL_WIDTH(ALUCTRL_WIDTH)) u_alu (
    .A(a_q), .B(b_q), .aluctrl(ctrl_q), .Z(z), .overflow(ovf)
  );
  always_comb begin
    accept     = state == IDLE && (req0_valid || req1_valid);
    req0_ready = accept && !win;
    req1_ready = accept && win;
    rsp0_valid = state == RESP && owner_q == OWN_EX;
    rsp1_valid = state == RESP && owner_q == OWN_HOST;
    busy       = state != IDLE;
    state_nx   = state == IDLE ? (accept ? EXEC : IDLE) :
                 state == EXEC ? RESP :
                 ((owner_q ? rsp1_ready : rsp0_ready) ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      owner_q  <= OWN_EX;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q     <= win ? req1_a : req0_a;
        b_q     <= win ? req1_b : req0_b;
        ctrl_q  <= win ? req1_ctrl : req0_ctrl;
        owner_q <= win;
      end
      if (state == EXEC) begin
        rsp_data <= z;
        rsp_zero <= ~|z;
        rsp_ovf  <= ovf;
      end
    end
endmodule
